mc_mem_responder: RTL and testbench

Unified instruction/data memory responder for the multicycle RISC-V core: the slave end of the processor's memory request interface. It accepts one read or write request at a time from the core's memory-access stage (fetch, load, store) and answers after a fixed, parameterised number of wait cycles with a one-cycle response pulse. The core's control FSM stalls on the response instead of assuming single-cycle memory. Word-organised storage with byte enables.

---
 rtl/mc_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_mc_mem_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_responder.sv
// Unified instruction/data memory responder: one request at a time, fixed-latency
// one-cycle response pulse. Define MC_MEM_MISALIGN_CHECK_EN to add the resp_err output.
module mc_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy
`ifdef MC_MEM_MISALIGN_CHECK_EN
  ,
  output logic        resp_err
`endif
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned CNT_INIT = (LATENCY >= 2) ? (LATENCY - 2) : 0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               mis_q, mis_d;
  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               mis_c;
  logic               enter_c;
  logic               ent_we_c;
  logic               ent_mis_c;
  logic [IDX_W-1:0]   ent_idx_c;
  logic               unused_addr_c;

  // Only the word index (and, with the check enabled, the low bits) matter.
  assign unused_addr_c = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

`ifdef MC_MEM_MISALIGN_CHECK_EN
  logic resp_err_q, resp_err_d;
  assign mis_c    = (req_addr[1:0] != 2'b00);
  assign resp_err = resp_err_q;
`else
  assign mis_c    = 1'b0;
`endif

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

  // Next-state, capture and response-entry logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    mis_d        = mis_q;
    resp_rdata_d = resp_rdata_q;
    resp_valid_d = 1'b0;
    enter_c      = 1'b0;
    ent_we_c     = we_q;
    ent_mis_c    = mis_q;
    ent_idx_c    = idx_q;
`ifdef MC_MEM_MISALIGN_CHECK_EN
    resp_err_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_addr[2 +: IDX_W];
          wdata_d = req_wdata;
          be_d    = req_be;
          mis_d   = mis_c;
          if (LATENCY == 1) begin
            // Single-cycle latency enters RESP straight from the live request.
            state_d   = S_RESP;
            enter_c   = 1'b1;
            ent_we_c  = req_we;
            ent_mis_c = mis_c;
            ent_idx_c = req_addr[2 +: IDX_W];
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(CNT_INIT);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          enter_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (enter_c) begin
      resp_valid_d = 1'b1;
`ifdef MC_MEM_MISALIGN_CHECK_EN
      resp_err_d   = ent_mis_c;
`endif
      if (!ent_we_c) begin
        resp_rdata_d = ent_mis_c ? 32'd0 : mem_q[ent_idx_c];
      end
    end

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      mis_q        <= 1'b0;
`ifdef MC_MEM_MISALIGN_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      mis_q        <= mis_d;
`ifdef MC_MEM_MISALIGN_CHECK_EN
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  // Writes commit on the edge that ends RESP; a reset mid-flight leaves RESP early.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && we_q && !mis_q && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed self-checking bench for mc_mem_responder (LATENCY=2 and LATENCY=1 instances).
module tb_mc_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid, busy;
  logic [31:0] resp_rdata;

  logic        req_valid1, req_we1;
  logic [31:0] req_addr1, req_wdata1;
  logic [3:0]  req_be1;
  logic        req_ready1, resp_valid1, busy1;
  logic [31:0] resp_rdata1;
`ifdef MC_MEM_MISALIGN_CHECK_EN
  logic        resp_err, resp_err1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
`ifdef MC_MEM_MISALIGN_CHECK_EN
    , .resp_err(resp_err)
`endif
  );

  mc_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we1), .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .busy(busy1)
`ifdef MC_MEM_MISALIGN_CHECK_EN
    , .resp_err(resp_err1)
`endif
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; measures latency and checks read data.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [31:0] exp, input string tag);
    int n;
    @(negedge clk);
    chk(32'(req_ready), 32'd1, {tag, "_ready"});
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_be = 4'hF;
    chk(32'(busy), 32'd1, {tag, "_busy"});
    n = 0;
    while (!resp_valid && n < 8) begin
      @(posedge clk); #1; n++;
    end
    chk(32'(n), 32'd1, {tag, "_latency"});
    if (!we) chk(resp_rdata, exp, {tag, "_rdata"});
`ifdef MC_MEM_MISALIGN_CHECK_EN
    chk(32'(resp_err), 32'd0, {tag, "_err"});
`endif
    @(posedge clk); #1;
    chk(32'(resp_valid), 32'd0, {tag, "_pulse"});
    chk(32'(req_ready), 32'd1, {tag, "_idle"});
  endtask

  // One request on the LATENCY=1 instance: response in the cycle right after accept.
  task automatic xact1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp, input logic exp_err,
                       input string tag);
    @(negedge clk);
    chk(32'(req_ready1), 32'd1, {tag, "_ready"});
    req_valid1 = 1'b1; req_we1 = we; req_addr1 = addr; req_wdata1 = wdata; req_be1 = be;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    chk(32'(resp_valid1), 32'd1, {tag, "_resp"});
    if (!we) chk(resp_rdata1, exp, {tag, "_rdata"});
`ifdef MC_MEM_MISALIGN_CHECK_EN
    chk(32'(resp_err1), 32'(exp_err), {tag, "_err"});
`else
    if (exp_err) chk(32'(resp_valid1), 32'd0, {tag, "_unexpected"});
`endif
    @(posedge clk); #1;
    chk(32'(resp_valid1), 32'd0, {tag, "_pulse"});
    chk(32'(req_ready1), 32'd1, {tag, "_idle"});
  endtask

  initial begin
    int acc, rsp;
    reset = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
    req_valid1 = 0; req_we1 = 0; req_addr1 = 0; req_wdata1 = 0; req_be1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk(32'(req_ready), 32'd1, "rst_ready");
    chk(32'(resp_valid), 32'd0, "rst_valid");
    chk(32'(busy), 32'd0, "rst_busy");
    chk(resp_rdata, 32'd0, "rst_rdata");
    @(negedge clk); reset = 1'b0;

    // Basic write then read
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, "wr10");
    xact(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, "rd10");

    // Byte enables and the empty-enable write
    xact(1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, "pre20");
    xact(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, "be0101");
    xact(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, "rd_be");
    xact(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 32'h0, "be0000");
    chk(resp_rdata, 32'h11BB_33DD, "rdata_hold");
    xact(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, "rd_be0");

    // Address wrap modulo 1 KiB
    xact(1'b1, 32'h400, 32'h5A5A_5A5A, 4'hF, 32'h0, "wr400");
    xact(1'b0, 32'h000, 32'h0, 4'h0, 32'h5A5A_5A5A, "rd000");

    // Continuous req_valid: accepts every third cycle, one response each
    xact(1'b1, 32'h40, 32'h4040_4040, 4'hF, 32'h0, "pre40");
    xact(1'b1, 32'h44, 32'h4444_4444, 4'hF, 32'h0, "pre44");
    acc = 0; rsp = 0;
    req_we = 1'b0; req_be = 4'h0; req_wdata = 32'h0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = (acc % 2 == 1) ? 32'h44 : 32'h40;
      chk(32'(req_ready), 32'((k % 3) == 0), "b2b_ready");
      chk(32'(resp_valid), 32'((k % 3) == 2), "b2b_valid");
      if (resp_valid) begin
        chk(resp_rdata, (rsp % 2 == 1) ? 32'h4444_4444 : 32'h4040_4040, "b2b_rdata");
        rsp++;
      end
      if (req_ready) acc++;
    end
    req_valid = 1'b0;
    chk(32'(acc), 32'd4, "b2b_accepts");
    chk(32'(rsp), 32'd4, "b2b_resps");
    @(posedge clk); #1;
    chk(32'(resp_valid), 32'd0, "b2b_no_extra");

    // Reset during WAIT discards the write
    xact(1'b1, 32'h30, 32'h0123_4567, 4'hF, 32'h0, "pre30");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk(32'(busy), 32'd1, "rstw_busy_before");
    #2 reset = 1'b1;
    #1;
    chk(32'(resp_valid), 32'd0, "rstw_valid");
    chk(32'(busy), 32'd0, "rstw_busy");
    chk(32'(req_ready), 32'd1, "rstw_ready");
    @(negedge clk); reset = 1'b0;
    xact(1'b0, 32'h30, 32'h0, 4'h0, 32'h0123_4567, "rd30_a");

    // Reset during RESP also blocks the commit
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk(32'(resp_valid), 32'd1, "rstr_in_resp");
    reset = 1'b1;
    #1;
    chk(32'(resp_valid), 32'd0, "rstr_valid");
    chk(resp_rdata, 32'd0, "rstr_rdata");
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    xact(1'b0, 32'h30, 32'h0, 4'h0, 32'h0123_4567, "rd30_b");

    // LATENCY=1 instance, including misaligned requests
    xact1(1'b1, 32'h10, 32'h600D_CAFE, 4'hF, 32'h0, 1'b0, "l1_wr");
    xact1(1'b0, 32'h10, 32'h0, 4'h0, 32'h600D_CAFE, 1'b0, "l1_rd");
`ifdef MC_MEM_MISALIGN_CHECK_EN
    xact1(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, "l1_mis_rd");
    xact1(1'b1, 32'h13, 32'h0000_0000, 4'hF, 32'h0, 1'b1, "l1_mis_wr");
    xact1(1'b0, 32'h10, 32'h0, 4'h0, 32'h600D_CAFE, 1'b0, "l1_rd_after");
`else
    xact1(1'b0, 32'h13, 32'h0, 4'h0, 32'h600D_CAFE, 1'b0, "l1_rd13");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
